uart_ctrl: RTL and testbench
============================

Name: uart_ctrl

Overview:
- Memory-mapped UART controller between the CPU data bus and the UART sender/receiver pair.
- Buffers CPU transmit bytes in a small FIFO and sequences the sender one byte at a time with a start pulse.
- Holds the transmit byte stable for the whole frame and captures each received byte.
- Exposes data/control/status registers and a level interrupt.

Parameters:
- TX_DEPTH, 4, TX FIFO depth in bytes; power of 2, minimum 2.
- BASE, 32'h40000018, byte address of TXD; RXD = BASE+4, CON = BASE+8.

Ports:
- sysclk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- addr  in  32  bus byte address
- wdata  in  32  bus write data
- we  in  1  bus write strobe, one sysclk per write
- re  in  1  bus read strobe
- rdata  out  32  read data; combinational from addr/re; 0 when unmapped or re=0
- tx_data  out  8  byte to sender
- tx_start  out  1  one-cycle start pulse to sender ctrl input
- tx_status  in  1  sender idle flag (1 = idle); asynchronous to sysclk
- rx_data  in  8  receiver byte
- rx_status  in  1  receiver byte-ready flag; asynchronous to sysclk
- irq  out  1  level interrupt

Behaviour:
- Reset (async, active-high) clears:
  - FIFO pointers/count, all CON bits, rx_buf, last_txd.
  - tx_data=0, tx_start=0, irq=0.
  - Both synchronizers preload idle values: tx_status=1, rx_status=0.
  - FSM returns to IDLE.
- Reset mid-frame abandons the byte; the sender finishes its frame on its own.
- Synchronization: tx_status and rx_status each pass through a 2-flop synchronizer; all logic below uses the synced values (tx_s, rx_s).
- Register map:
  - TXD write: pushes wdata[7:0] and updates last_txd. Write while FIFO full is dropped and sets CON[7] ovf_tx.
  - TXD read: {24'b0, last_txd}.
  - RXD read: {24'b0, rx_buf}. A read strobe clears rx_valid at that clock edge.
  - CON bits:
    - [0] tx_ie (RW)
    - [1] rx_ie (RW)
    - [2] rx_valid (RO)
    - [3] tx_done (sticky, write-1-clear)
    - [4] tx_busy (RO; FSM not IDLE or FIFO non-empty)
    - [5] tx_full (RO)
    - [6] rx_ovr (sticky, W1C)
    - [7] ovf_tx (sticky, W1C)
    - others read 0
  - A CON write updates bits 1:0 and clears the W1C bits where wdata is 1.
- TX FSM:
  - IDLE: FIFO non-empty -> LOAD.
  - LOAD: tx_data <= FIFO head (no pop) -> START.
  - START: tx_start=1 for exactly this cycle -> WAIT_BUSY.
  - WAIT_BUSY: tx_s==0 -> WAIT_DONE.
  - WAIT_DONE: tx_s==1 -> pop FIFO, set tx_done -> IDLE.
- tx_data is held constant from LOAD until the pop; it never changes while the sender is mid-frame.
- Byte-to-byte minimum gap is 3 sysclk plus synchronizer delay.
- Simultaneous push and pop on a full FIFO is allowed: count is unchanged and no overflow.
- Pointers wrap modulo TX_DEPTH; count is log2(TX_DEPTH)+1 bits.
- RX capture: on a rising edge of rx_s, rx_buf <= rx_data and rx_valid <= 1.
  - If rx_valid was already 1 and is not being cleared this cycle, also set rx_ovr.
  - Capture in the same cycle as an RXD read: capture wins, rx_valid stays 1, no overrun.
- irq is registered: (tx_ie & tx_done) | (rx_ie & rx_valid), one cycle after the status change.
- Simultaneous we and re to the same address: the write takes effect and the read returns the pre-write value.

Test Plan:
- Reset asserted mid-WAIT_DONE -> immediately tx_start=0, irq=0, CON reads 0; with tx_status=1 and rx_status=0, after 2 clocks the FSM stays in IDLE.
- Write TXD=0x55 with a sender model (busy 10 baud periods) -> tx_data=0x55 before tx_start; exactly one tx_start pulse; tx_data stable until tx_status returns 1; then CON[3]=1; irq=1 only if tx_ie=1.
- Write 5 bytes 0x01..0x05 back-to-back with TX_DEPTH=4 while the sender is busy -> first 4 bytes sent in order 0x01..0x04; 0x05 dropped; CON[7]=1; CON[5]=1 while full.
- Receiver raises rx_status with rx_data=0xA3 -> RXD reads 0xA3; CON[2]=1; a second rx_status rise with 0x3C before the read -> RXD=0x3C, CON[6]=1; RXD read clears CON[2].
- Write CON=0x48 after tx_done and rx_ovr are set -> both bits clear; tx_ie/rx_ie both become 0 (bits 1:0 of 0x48 are 0); irq deasserts the next cycle.
- RXD read coincident with a rx_status rising edge -> rx_buf holds the new byte, CON[2]=1, CON[6]=0.

Source files
------------

// File: rtl/uart_ctrl_if.sv
`timescale 1ns/1ps
// CPU-side memory-mapped bus between the processor and the UART controller.
interface uart_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        we;
  logic        re;

  modport master (output addr, wdata, we, re, input rdata);
  modport slave  (input addr, wdata, we, re, output rdata);
endinterface

// File: rtl/uart_ctrl.sv
`timescale 1ns/1ps
// UART controller: TX byte FIFO feeding a one-byte-at-a-time sender sequencer,
// RX byte capture, TXD/RXD/CON registers and a registered level interrupt.
module uart_ctrl #(
  parameter int          TX_DEPTH = 4,
  parameter logic [31:0] BASE     = 32'h40000018
) (
  input  logic            sysclk,
  input  logic            reset,
  uart_ctrl_if.slave      bus,
  output logic [7:0]      tx_data,
  output logic            tx_start,
  input  logic            tx_status,
  input  logic [7:0]      rx_data,
  input  logic            rx_status,
  output logic            irq
);
  localparam int AW = $clog2(TX_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} tx_state_t;
  tx_state_t state_reg, state_next;

  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [7:0]    last_txd_reg, rx_buf_reg;
  logic          tx_meta_reg, tx_s, rx_meta_reg, rx_s, rx_s_d_reg;
  logic          tx_ie_reg, rx_ie_reg, rx_valid_reg, tx_done_reg, rx_ovr_reg, ovf_tx_reg;
  logic          hit_txd, hit_rxd, hit_con, con_we, rd_rxd, push_req, push, pop;
  logic          load_en, full, busy, rx_rise;
  logic [7:0]    con_val;
  logic          unused_wdata;

  assign hit_txd  = (bus.addr == BASE);
  assign hit_rxd  = (bus.addr == BASE + 32'd4);
  assign hit_con  = (bus.addr == BASE + 32'd8);
  assign con_we   = bus.we && hit_con;
  assign rd_rxd   = bus.re && hit_rxd;
  assign push_req = bus.we && hit_txd;
  assign full     = (count_reg == (AW+1)'(TX_DEPTH));
  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign push     = push_req && (!full || pop);
  assign busy     = (state_reg != IDLE) || (count_reg != '0);
  assign rx_rise  = rx_s && !rx_s_d_reg;
  assign unused_wdata = ^bus.wdata[31:8];

  // Status inputs come from the baud domain; idle values preload on reset.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tx_meta_reg <= 1'b1;
      tx_s        <= 1'b1;
      rx_meta_reg <= 1'b0;
      rx_s        <= 1'b0;
      rx_s_d_reg  <= 1'b0;
    end else begin
      tx_meta_reg <= tx_status;
      tx_s        <= tx_meta_reg;
      rx_meta_reg <= rx_status;
      rx_s        <= rx_meta_reg;
      rx_s_d_reg  <= rx_s;
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) fifo_mem[wr_ptr_reg] <= bus.wdata[7:0];
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    tx_start   = 1'b0;
    load_en    = 1'b0;
    pop        = 1'b0;
    case (state_reg)
      IDLE:      if (count_reg != '0) state_next = LOAD;
      LOAD: begin
        load_en    = 1'b1;
        state_next = START;
      end
      START: begin
        tx_start   = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: if (!tx_s) state_next = WAIT_DONE;
      WAIT_DONE: if (tx_s) begin
        pop        = 1'b1;
        state_next = IDLE;
      end
      default:   state_next = IDLE;
    endcase
  end

  // Status/control registers; sticky bits give priority to a new set event.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tx_data      <= 8'h00;
      last_txd_reg <= 8'h00;
      rx_buf_reg   <= 8'h00;
      tx_ie_reg    <= 1'b0;
      rx_ie_reg    <= 1'b0;
      rx_valid_reg <= 1'b0;
      tx_done_reg  <= 1'b0;
      rx_ovr_reg   <= 1'b0;
      ovf_tx_reg   <= 1'b0;
      irq          <= 1'b0;
    end else begin
      if (load_en)  tx_data      <= fifo_mem[rd_ptr_reg];
      if (push_req) last_txd_reg <= bus.wdata[7:0];
      if (con_we) begin
        tx_ie_reg <= bus.wdata[0];
        rx_ie_reg <= bus.wdata[1];
      end
      if (push_req && !push)          ovf_tx_reg <= 1'b1;
      else if (con_we && bus.wdata[7]) ovf_tx_reg <= 1'b0;
      if (pop)                         tx_done_reg <= 1'b1;
      else if (con_we && bus.wdata[3]) tx_done_reg <= 1'b0;
      if (rx_rise) begin
        rx_buf_reg   <= rx_data;
        rx_valid_reg <= 1'b1;
      end else if (rd_rxd) begin
        rx_valid_reg <= 1'b0;
      end
      if (rx_rise && rx_valid_reg && !rd_rxd) rx_ovr_reg <= 1'b1;
      else if (con_we && bus.wdata[6])        rx_ovr_reg <= 1'b0;
      irq <= (tx_ie_reg && tx_done_reg) || (rx_ie_reg && rx_valid_reg);
    end
  end

  assign con_val = {ovf_tx_reg, rx_ovr_reg, full, busy,
                    tx_done_reg, rx_valid_reg, rx_ie_reg, tx_ie_reg};

  always_comb begin
    bus.rdata = 32'h0;
    if (bus.re) begin
      if (hit_txd)      bus.rdata = {24'h0, last_txd_reg};
      else if (hit_rxd) bus.rdata = {24'h0, rx_buf_reg};
      else if (hit_con) bus.rdata = {24'h0, con_val};
    end
  end
endmodule

// File: tb/tb_uart_ctrl.sv
`timescale 1ns/1ps
// Directed bench for uart_ctrl with a behavioural sender that stays busy 40 sysclk per byte.
module tb_uart_ctrl;
  localparam logic [31:0] TXD = 32'h40000018;
  localparam logic [31:0] RXD = 32'h4000001C;
  localparam logic [31:0] CON = 32'h40000020;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [7:0] tx_data, rx_data;
  logic       tx_start, tx_status, rx_status, irq;
  int         n_vec = 0, n_miss = 0, start_cnt = 0, rst_gen = 0;
  logic [7:0] sent_q [$];
  logic [31:0] d;

  uart_ctrl_if bus ();

  uart_ctrl #(.TX_DEPTH(4), .BASE(32'h40000018)) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .bus      (bus),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_status(tx_status),
    .rx_data  (rx_data),
    .rx_status(rx_status),
    .irq      (irq)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    @(negedge sysclk);
    bus.addr = a; bus.wdata = v; bus.we = 1'b1;
    @(negedge sysclk);
    bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    @(negedge sysclk);
    bus.addr = a; bus.re = 1'b1;
    #1 v = bus.rdata;
    @(negedge sysclk);
    bus.re = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge sysclk);
    rx_data = b; rx_status = 1'b1;
    repeat (4) @(negedge sysclk);
    rx_status = 1'b0;
    repeat (4) @(negedge sysclk);
  endtask

  task automatic wait_tx_idle(input string tag);
    logic [31:0] v;
    v = 32'h10;
    for (int i = 0; i < 400 && v[4]; i++) bus_read(CON, v);
    chk(tag, {31'h0, v[4]}, 32'h0);
  endtask

  // Sender: captures tx_data on the start pulse, busy for 40 clocks, checks the byte held.
  initial begin
    logic [7:0] cur_b;
    int r0;
    tx_status = 1'b1;
    forever begin
      @(negedge sysclk);
      if (tx_start === 1'b1) begin
        cur_b = tx_data;
        r0 = rst_gen;
        sent_q.push_back(cur_b);
        tx_status = 1'b0;
        repeat (40) @(negedge sysclk);
        if (rst_gen == r0) chk("tx_hold", {24'h0, tx_data}, {24'h0, cur_b});
        tx_status = 1'b1;
      end
    end
  end

  always @(negedge sysclk) if (tx_start === 1'b1) start_cnt++;

  initial begin
    bus.addr = '0; bus.wdata = '0; bus.we = 1'b0; bus.re = 1'b0;
    rx_data = 8'h00; rx_status = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge sysclk);
    chk("rst_tx_start", {31'h0, tx_start}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    reset = 1'b0;
    bus_read(CON, d);  chk("rst_con", d, 32'h0);

    // Single byte with tx_ie set, then one with tx_ie clear
    bus_write(CON, 32'h01);
    bus_write(TXD, 32'h55);
    wait_tx_idle("idle_55");
    chk("sent_55", {24'h0, sent_q[0]}, 32'h55);
    chk("starts_1", start_cnt, 1);
    bus_read(CON, d);  chk("con_done_ie", d, 32'h09);
    chk("irq_tx", {31'h0, irq}, 32'h1);
    bus_read(TXD, d);  chk("txd_rd", d, 32'h55);
    bus_write(CON, 32'h08);
    bus_read(CON, d);  chk("con_clr", d, 32'h0);
    bus_write(TXD, 32'h66);
    wait_tx_idle("idle_66");
    bus_read(CON, d);  chk("con_done_noie", d, 32'h08);
    chk("irq_noie", {31'h0, irq}, 32'h0);
    chk("starts_2", start_cnt, 2);
    bus_write(CON, 32'h08);

    // Five back-to-back bytes into a 4-deep FIFO
    for (int i = 1; i <= 4; i++) bus_write(TXD, 32'(i));
    bus_read(CON, d);  chk("con_full", d, 32'h30);
    bus_write(TXD, 32'h05);
    bus_read(CON, d);  chk("con_ovf", d, 32'hB0);
    wait_tx_idle("idle_burst");
    for (int i = 0; i < 4; i++) chk($sformatf("burst_%0d", i), {24'h0, sent_q[2+i]}, 32'(i + 1));
    chk("starts_6", start_cnt, 6);
    bus_read(CON, d);  chk("con_burst_end", d, 32'h88);
    bus_write(CON, 32'h88);
    bus_read(CON, d);  chk("con_burst_clr", d, 32'h0);

    // Receive, read, overrun
    bus_write(CON, 32'h02);
    rx_pulse(8'hA3);
    bus_read(CON, d);  chk("con_rxv", d, 32'h06);
    chk("irq_rx", {31'h0, irq}, 32'h1);
    bus_read(RXD, d);  chk("rxd_a3", d, 32'hA3);
    bus_read(CON, d);  chk("con_rxv_clr", d, 32'h02);
    chk("irq_rx_clr", {31'h0, irq}, 32'h0);
    rx_pulse(8'h77);
    rx_pulse(8'h3C);
    bus_read(CON, d);  chk("con_ovr", d, 32'h46);
    bus_read(RXD, d);  chk("rxd_3c", d, 32'h3C);
    bus_read(CON, d);  chk("con_ovr_rd", d, 32'h42);

    // W1C of tx_done and rx_ovr with enables dropped
    bus_write(TXD, 32'h5A);
    wait_tx_idle("idle_5a");
    bus_read(CON, d);  chk("con_pre_w1c", d, 32'h4A);
    bus_write(CON, 32'h03);
    bus_read(CON, d);  chk("con_ie", d, 32'h4B);
    chk("irq_pre_w1c", {31'h0, irq}, 32'h1);
    bus_write(CON, 32'h48);
    chk("irq_lag", {31'h0, irq}, 32'h1);
    @(negedge sysclk);
    chk("irq_w1c", {31'h0, irq}, 32'h0);
    bus_read(CON, d);  chk("con_w1c", d, 32'h0);

    // RXD read coinciding with a capture
    rx_pulse(8'h11);
    bus_read(CON, d);  chk("con_rx11", d, 32'h04);
    @(negedge sysclk);
    rx_data = 8'hC7; rx_status = 1'b1;
    @(negedge sysclk);
    bus_read(RXD, d);  chk("rxd_coinc", d, 32'h11);
    rx_status = 1'b0;
    repeat (3) @(negedge sysclk);
    bus_read(CON, d);  chk("con_coinc", d, 32'h04);
    bus_read(RXD, d);  chk("rxd_c7", d, 32'hC7);
    bus_read(CON, d);  chk("con_coinc_clr", d, 32'h0);

    // Reset in the middle of a frame
    bus_write(CON, 32'h03);
    rx_pulse(8'h21);
    bus_write(TXD, 32'h99);
    repeat (20) @(negedge sysclk);
    chk("irq_pre_rst", {31'h0, irq}, 32'h1);
    chk("sender_busy", {31'h0, tx_status}, 32'h0);
    reset = 1'b1; rst_gen++;
    bus.addr = CON; bus.re = 1'b1;
    #1;
    chk("mid_rst_con", bus.rdata, 32'h0);
    chk("mid_rst_start", {31'h0, tx_start}, 32'h0);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    chk("mid_rst_txdata", {24'h0, tx_data}, 32'h0);
    bus.re = 1'b0;
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    repeat (3) @(negedge sysclk);
    bus_read(CON, d);  chk("post_rst_con", d, 32'h0);
    for (int i = 0; i < 200 && tx_status !== 1'b1; i++) @(negedge sysclk);
    chk("sender_released", {31'h0, tx_status}, 32'h1);
    repeat (6) @(negedge sysclk);
    bus_read(CON, d);  chk("post_rst_idle", d, 32'h0);
    chk("starts_8", start_cnt, 8);
    chk("sent_99", {24'h0, sent_q[7]}, 32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
